// File: rtl/sm_cpu.sv
// Single-cycle MIPS-subset core: one instruction per clock, word-indexed PC.
// Optional macro SM_CPU_MUL_EN adds the MUL instruction (combinational multiplier).
module sm_cpu_regfile (
  input  logic        clk,
  input  logic        wrEn,
  input  logic [4:0]  wrAddr,
  input  logic [31:0] wrData,
  input  logic [4:0]  rdAddrA,
  input  logic [4:0]  rdAddrB,
  input  logic [4:0]  rdAddrC,
  output logic [31:0] rdDataA,
  output logic [31:0] rdDataB,
  output logic [31:0] rdDataC
);

  logic [31:0] rf [0:31];

  // No reset: contents survive rst_n; entry 0 is never written and always reads zero
  always_ff @(posedge clk) begin
    if (wrEn && (wrAddr != 5'd0)) begin
      rf[wrAddr] <= wrData;
    end
  end

  assign rdDataA = (rdAddrA == 5'd0) ? 32'h0 : rf[rdAddrA];
  assign rdDataB = (rdAddrB == 5'd0) ? 32'h0 : rf[rdAddrB];
  assign rdDataC = (rdAddrC == 5'd0) ? 32'h0 : rf[rdAddrC];

endmodule

module sm_cpu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  extraInput,
  input  logic [4:0]  regAddr,
  output logic [31:0] regData,
  output logic [31:0] imAddr,
  input  logic [31:0] imData
);

  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] pcPlus1;
  logic [31:0] nextPc;
  logic [31:0] rsVal;
  logic [31:0] rtVal;
  logic [31:0] dbgVal;
  logic [31:0] wrData;
  logic [4:0]  wrAddr;
  logic        wrEn;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sa;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] immSext;
  logic [31:0] immZext;

  assign instr   = imData;
  assign imAddr  = pc;
  assign op      = instr[31:26];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign sa      = instr[10:6];
  assign funct   = instr[5:0];
  assign imm     = instr[15:0];
  assign immSext = {{16{imm[15]}}, imm};
  assign immZext = {16'h0000, imm};
  assign pcPlus1 = pc + 32'd1;

`ifdef SM_CPU_MUL_EN
  logic [31:0] mulProd;
  assign mulProd = rsVal * rtVal;
`endif

  always_comb begin
    nextPc = pcPlus1;
    wrEn   = 1'b0;
    wrAddr = rd;
    wrData = 32'h0;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100001: begin wrEn = 1'b1; wrData = rsVal + rtVal; end
          6'b100011: begin wrEn = 1'b1; wrData = rsVal - rtVal; end
          6'b100101: begin wrEn = 1'b1; wrData = rsVal | rtVal; end
          6'b101011: begin wrEn = 1'b1; wrData = (rsVal < rtVal) ? 32'd1 : 32'd0; end
          6'b000010: begin wrEn = 1'b1; wrData = rtVal >> sa; end
          default: ;
        endcase
      end
      6'b001001: begin wrEn = 1'b1; wrAddr = rt; wrData = rsVal + immSext; end
      6'b001101: begin wrEn = 1'b1; wrAddr = rt; wrData = rsVal | immZext; end
      6'b001111: begin wrEn = 1'b1; wrAddr = rt; wrData = {imm, 16'h0000}; end
      6'b100011: begin wrEn = 1'b1; wrAddr = rt; wrData = {24'h0, extraInput}; end
      6'b000100: if (rsVal == rtVal) nextPc = pcPlus1 + immSext;
      6'b000101: if (rsVal != rtVal) nextPc = pcPlus1 + immSext;
      6'b000010: nextPc = {pcPlus1[31:26], instr[25:0]};
`ifdef SM_CPU_MUL_EN
      6'b011100: if (funct == 6'b000010) begin wrEn = 1'b1; wrData = mulProd; end
`endif
      default: ;
    endcase
  end

  // Held in reset the core must not retire, so register writes are suppressed too
  sm_cpu_regfile rf (
    .clk     (clk),
    .wrEn    (wrEn & rst_n),
    .wrAddr  (wrAddr),
    .wrData  (wrData),
    .rdAddrA (rs),
    .rdAddrB (rt),
    .rdAddrC (regAddr),
    .rdDataA (rsVal),
    .rdDataB (rtVal),
    .rdDataC (dbgVal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= 32'h0;
    end else begin
      pc <= nextPc;
    end
  end

  assign regData = (regAddr == 5'd0) ? pc : dbgVal;

endmodule

// File: tb/tb_sm_cpu.sv
// Self-checking bench for sm_cpu: directed programs plus random programs run
// in lockstep with an instruction-level interpreter of the ISA.
module tb_sm_cpu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  extraInput;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic [31:0] imAddr;
  logic [31:0] imData;

  logic [31:0] imem [0:63];
  assign imData = imem[imAddr[5:0]];

  always #5 clk = ~clk;

  sm_cpu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .extraInput (extraInput),
    .regAddr    (regAddr),
    .regData    (regData),
    .imAddr     (imAddr),
    .imData     (imData)
  );

  int compareCount = 0;
  int mismatchCount = 0;

  logic [31:0] mRegs [0:31];
  bit          mKnown [0:31];
  logic [31:0] mPc;
  bit          nextRst;
  bit          randExtra;
  logic [7:0]  fixedExtra;
  int          forceAddr;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] encR(input int rs, input int rt, input int rd, input int sa, input logic [5:0] fn);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'(sa), fn};
  endfunction

  function automatic logic [31:0] encI(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  // Instruction-level interpreter: what the ISA says one retired instruction does
  task automatic modelStep();
    logic [31:0] ins, a, b, val, npc, sext;
    logic [5:0]  op, fn;
    int          rs, rt, rd, sa, dst;
    bit          wr, vk;
    ins  = imem[mPc[5:0]];
    op   = ins[31:26];
    fn   = ins[5:0];
    rs   = int'(ins[25:21]);
    rt   = int'(ins[20:16]);
    rd   = int'(ins[15:11]);
    sa   = int'(ins[10:6]);
    a    = mRegs[rs];
    b    = mRegs[rt];
    sext = 32'($signed(ins[15:0]));
    npc  = mPc + 32'd1;
    wr   = 1'b0;
    vk   = mKnown[rs] && mKnown[rt];
    val  = 32'h0;
    dst  = rt;
    case (op)
      6'h00: begin
        dst = rd;
        wr  = 1'b1;
        case (fn)
          6'h21: val = a + b;
          6'h23: val = a - b;
          6'h25: val = a | b;
          6'h2b: val = (a < b) ? 32'd1 : 32'd0;
          6'h02: begin val = b >> sa; vk = mKnown[rt]; end
          default: wr = 1'b0;
        endcase
      end
      6'h09: begin wr = 1'b1; vk = mKnown[rs]; val = a + sext; end
      6'h0d: begin wr = 1'b1; vk = mKnown[rs]; val = a | {16'h0, ins[15:0]}; end
      6'h0f: begin wr = 1'b1; vk = 1'b1; val = {ins[15:0], 16'h0}; end
      6'h23: begin wr = 1'b1; vk = 1'b1; val = {24'h0, extraInput}; end
      6'h04: if (a == b) npc = mPc + 32'd1 + sext;
      6'h05: if (a != b) npc = mPc + 32'd1 + sext;
      6'h02: npc = {npc[31:26], ins[25:0]};
`ifdef SM_CPU_MUL_EN
      6'h1c: if (fn == 6'h02) begin wr = 1'b1; dst = rd; val = a * b; end
`endif
      default: ;
    endcase
    if (wr && dst != 0) begin
      mRegs[dst]  = val;
      mKnown[dst] = vk;
    end
    mPc = npc;
  endtask

  task automatic applyStimulus();
    rst_n      = nextRst;
    extraInput = randExtra ? 8'($urandom) : fixedExtra;
    regAddr    = (forceAddr >= 0) ? 5'(forceAddr) : 5'($urandom);
  endtask

  task automatic runCycle();
    @(negedge clk);
    applyStimulus();
    if (!rst_n) mPc = 32'h0;
    #1;
    checkOutput("imAddr", imAddr, mPc);
    if (regAddr == 5'd0) checkOutput("regDataPc", regData, mPc);
    else if (mKnown[regAddr]) checkOutput("regData", regData, mRegs[regAddr]);
    if (rst_n) modelStep();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) runCycle();
  endtask

  task automatic checkReg(input string tag, input int r, input logic [31:0] expected);
    forceAddr = r;
    runCycle();
    checkOutput(tag, regData, expected);
    forceAddr = -1;
  endtask

  // Imem is only rewritten once reset is really low, so nothing retires meanwhile
  task automatic enterReset();
    nextRst = 1'b0;
    runCycle();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    runCycle();
  endtask

  task automatic asyncResetCheck();
    @(negedge clk);
    regAddr = 5'd0;
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncImAddr", imAddr, 32'h0);
    checkOutput("asyncRegData", regData, 32'h0);
    mPc     = 32'h0;
    nextRst = 1'b0;
  endtask

  function automatic logic [31:0] randInstr();
    int          k, r1, r2, d;
    logic [15:0] off;
    k   = int'($urandom_range(0, 13));
    r1  = int'($urandom_range(0, 7));
    r2  = int'($urandom_range(0, 7));
    d   = int'($urandom_range(0, 15));
    off = 16'($urandom_range(0, 8)) - 16'd4;
    case (k)
      0:  return encR(r1, r2, d, 0, 6'h21);
      1:  return encR(r1, r2, d, 0, 6'h23);
      2:  return encR(r1, r2, d, 0, 6'h25);
      3:  return encR(r1, r2, d, 0, 6'h2b);
      4:  return encR(0, r2, d, int'($urandom_range(0, 31)), 6'h02);
      5:  return encI(6'h09, r1, d, 16'($urandom));
      6:  return encI(6'h0d, r1, d, 16'($urandom));
      7:  return encI(6'h0f, r1, d, 16'($urandom));
      8:  return encI(6'h23, r1, d, 16'($urandom));
      9:  return encI(6'h04, r1, r2, off);
      10: return encI(6'h05, r1, r2, off);
      11: return {6'h02, 20'($urandom), 6'($urandom_range(0, 63))};
      12: return {6'h1c, 5'(r1), 5'(r2), 5'(d), 5'd0, 6'h02};
      default: return ($urandom_range(0, 1) == 0) ? 32'h0 : {6'h3f, 26'($urandom)};
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bodyCount;
    rst_n = 1'b0; nextRst = 1'b0; randExtra = 1'b1; fixedExtra = 8'h00; forceAddr = -1;
    regAddr = 5'd0; extraInput = 8'h00; mPc = 32'h0;
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    for (int i = 0; i < 32; i++) begin mRegs[i] = 32'h0; mKnown[i] = (i == 0); end

    // Reset held four cycles, then PC counts through nops
    for (int i = 0; i < 4; i++) begin
      runCycle();
      checkOutput("resetPc", imAddr, 32'h0);
    end
    nextRst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      runCycle();
      checkOutput("resetRelease", imAddr, 32'(i));
    end

    // ALU program
    enterReset();
    imem[0] = encI(6'h09, 0, 2, 16'd5);
    imem[1] = encI(6'h09, 0, 3, 16'hFFFF);
    imem[2] = encR(2, 3, 4, 0, 6'h21);
    imem[3] = encR(2, 3, 5, 0, 6'h23);
    imem[4] = encR(2, 3, 6, 0, 6'h2b);
    imem[5] = encR(0, 3, 7, 4, 6'h02);
    imem[6] = encI(6'h0f, 0, 8, 16'h1234);
    imem[7] = encI(6'h0d, 8, 8, 16'h5678);
    imem[8] = encI(6'h04, 0, 0, 16'hFFFF);
    nextRst = 1'b1;
    runCycles(12);
    checkReg("addu", 4, 32'd4);
    checkReg("subu", 5, 32'd6);
    checkReg("sltu", 6, 32'd1);
    checkReg("srl", 7, 32'h0FFFFFFF);
    checkReg("luiOri", 8, 32'h12345678);
    checkOutput("beqSelfLoop", imAddr, 32'd8);

    // Countdown loop with bne, then beq self-loop
    enterReset();
    imem[0] = encI(6'h09, 0, 2, 16'd3);
    imem[1] = encI(6'h09, 2, 2, 16'hFFFF);
    imem[2] = encI(6'h05, 2, 0, 16'hFFFE);
    imem[3] = encI(6'h04, 0, 0, 16'hFFFF);
    nextRst = 1'b1;
    bodyCount = 0;
    for (int i = 0; i < 12; i++) begin
      runCycle();
      if (imAddr == 32'd1) bodyCount++;
    end
    checkOutput("loopCount", 32'(bodyCount), 32'd3);
    checkReg("loopReg", 2, 32'd0);
    checkOutput("loopExit", imAddr, 32'd3);

    // Jump from 10 to 3, and writes to $0 are discarded
    enterReset();
    imem[0]  = encI(6'h09, 0, 1, 16'h0055);
    imem[1]  = encI(6'h09, 0, 0, 16'd7);
    imem[2]  = encR(0, 0, 1, 0, 6'h21);
    imem[10] = {6'h02, 26'd3};
    nextRst = 1'b1;
    runCycles(11);
    checkOutput("atJump", imAddr, 32'd10);
    runCycle();
    checkOutput("jumpTarget", imAddr, 32'd3);
    checkReg("r0IsPc", 0, 32'd4);
    checkReg("r0Discard", 1, 32'd0);

    // LW from extraInput, then MUL (or untouched $4 without the multiplier)
    enterReset();
    randExtra  = 1'b0;
    fixedExtra = 8'hA5;
    imem[0] = encI(6'h23, 9, 5, 16'h1234);
    imem[1] = encI(6'h09, 0, 2, 16'd7);
    imem[2] = encI(6'h09, 0, 3, 16'd6);
    imem[3] = encI(6'h09, 0, 4, 16'd99);
    imem[4] = {6'h1c, 5'd2, 5'd3, 5'd4, 5'd0, 6'h02};
    imem[5] = encI(6'h04, 0, 0, 16'hFFFF);
    nextRst = 1'b1;
    runCycles(10);
    checkReg("lw", 5, 32'h000000A5);
`ifdef SM_CPU_MUL_EN
    checkReg("mul", 4, 32'd42);
`else
    checkReg("mulDisabled", 4, 32'd99);
`endif
    randExtra = 1'b1;

    // Random programs against the interpreter
    for (int round = 0; round < 3; round++) begin
      enterReset();
      for (int r = 1; r < 8; r++) imem[r - 1] = encI(6'h09, 0, r, 16'($urandom));
      for (int a = 7; a < 64; a++) imem[a] = randInstr();
      nextRst = 1'b1;
      if (round == 1) begin
        runCycles(120);
        asyncResetCheck();
        runCycles(3);
        nextRst = 1'b1;
        runCycles(130);
      end else begin
        runCycles(250);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/sm_cpu.md
SM_CPU -- requirements
Module: sm_cpu

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 extraInput  input  8  external data port, read by the LW instruction.
REQ-004 regAddr  input  5  debug register-file read address.
REQ-005 regData  output  32  debug read data: PC when regAddr=0, otherwise rf[regAddr]; combinational.
REQ-006 imAddr  output  32  instruction memory word address, equal to PC; combinational.
REQ-007 imData  input  32  instruction word for imAddr, same cycle, from companion sm_rom(a[31:0] in, rd[31:0] out).
REQ-008 Hierarchy SHALL expose the register file as instance `rf` with array `rf[0:31]`, and the decoded instruction as signal `instr`.

Function
REQ-009 Single-cycle core: instr=imData; one instruction retires per clk edge.
REQ-010 PC is a word index; default next PC = PC+1 (32-bit wrap).
REQ-011 rf: 32x32, two combinational reads (rs, rt) plus debug port; one synchronous write; rf[0] reads 0 and writes to it are discarded.
REQ-012 Fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], sa[10:6], funct[5:0], imm[15:0].
REQ-013 op=000000 (SPECIAL), by funct: ADDU 100001 rd=rs+rt; SUBU 100011 rd=rs-rt; OR 100101 rd=rs|rt; SLTU 101011 rd=(rs<rt unsigned)?1:0; SRL 000010 rd=rt>>sa (logical).
REQ-014 ADDIU op 001001: rt=rs+signext(imm), no overflow trap.
REQ-015 ORI op 001101: rt=rs|zeroext(imm).
REQ-016 LUI op 001111: rt={imm,16'h0000}.
REQ-017 LW op 100011: rt={24'b0,extraInput}; rs/imm ignored; no memory access.
REQ-018 BEQ op 000100: if rs==rt then PC=PC+1+signext(imm), else PC+1; no delay slot.
REQ-019 BNE op 000101: if rs!=rt then PC=PC+1+signext(imm), else PC+1.
REQ-020 J op 000010: PC={PC+1[31:26], instr[25:0]}; no delay slot.
REQ-021 MUL op 011100 funct 000010 (when enabled, REQ-027): rd=low 32 bits of rs*rt.
REQ-022 Any other encoding, including 32'h0: no register write, PC=PC+1.
REQ-023 Arithmetic is 32-bit modulo; no exceptions or stalls.
REQ-024 sm_rom: combinational; rd=mem[a[5:0]], 64 words loaded from "program.hex" ($readmemh) at elaboration.

Reset
REQ-025 rst_n low SHALL force PC=0 immediately (asynchronously); imAddr=0, regData with regAddr=0 reads 0.
REQ-026 Register file is not reset; its contents persist through reset. First fetch after release is from address 0 on the next rising edge.

Configuration
REQ-027 Macro SM_CPU_MUL_EN: defined -> MUL per REQ-021 with a combinational multiplier; undefined -> MUL encoding treated per REQ-022, no multiplier logic.

Verification
REQ-028 Reset: rst_n=0 for 4 cycles -> PC=0 throughout; after release PC goes 0,1,2,3 on successive edges running nops.
REQ-029 ALU: addiu $2,$0,5; addiu $3,$0,-1; addu $4,$2,$3; subu $5,$2,$3; sltu $6,$2,$3; srl $7,$3,4; lui $8,0x1234; ori $8,$8,0x5678 -> $4=4, $5=6, $6=1, $7=0x0FFFFFFF, $8=0x12345678.
REQ-030 Branches: $2=3, loop "addiu $2,$2,-1; bne $2,$0,-2" -> loop body executes 3 times, $2=0, then falls through; beq $0,$0,-1 -> PC constant.
REQ-031 Jump at PC=10 with target 3 -> next PC=3; writes to $0 -> regData with regAddr=0 still PC, rf[0]=0.
REQ-032 LW with extraInput=0xA5 -> rt=0x000000A5; with SM_CPU_MUL_EN, $2=7, $3=6, mul $4,$2,$3 -> $4=42; without the macro -> $4 unchanged.
